// File: rtl/rll_pkg.sv
// Shared types and helpers for the RLL keyed gate bank.
package rll_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2,
        ACTIVE  = 2'd3
    } rll_key_state_e;

    // Upper bound on DATA_W/KEY_W; the counter is sized to hold KEY_W+1 at this bound.
    localparam int unsigned RLL_MAX_W = 64;
    localparam int unsigned RLL_CNT_W = $clog2(RLL_MAX_W + 2);

    // Bits where key and pol are both zero pass through untouched.
    function automatic logic [RLL_MAX_W-1:0] apply_key(
        input logic [RLL_MAX_W-1:0] data,
        input logic [RLL_MAX_W-1:0] key,
        input logic [RLL_MAX_W-1:0] pol
    );
        return data ^ key ^ pol;
    endfunction

endpackage

// File: rtl/rll_key_shifter.sv
// Serial key shadow register with bit counter and optional even-parity check.
// Parity support is enabled by RLL_KEY_PARITY_EN.
module rll_key_shifter
    import rll_pkg::*;
#(
    parameter int unsigned KEY_W    = 32,
    parameter int unsigned LOAD_LEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             cnt_clr,
    input  logic             shift_en,
    input  logic             key_bit,
    output logic [KEY_W-1:0] shadow,
    output logic             last,
    output logic             full,
    output logic             parity_ok
);

    localparam logic [RLL_CNT_W-1:0] LOAD_LEN_C = RLL_CNT_W'(LOAD_LEN);
    localparam logic [RLL_CNT_W-1:0] LAST_C     = RLL_CNT_W'(LOAD_LEN - 1);

    logic [RLL_CNT_W-1:0] cnt;
    logic [KEY_W-1:0]     shadow_shl;

    // Shift without slicing so KEY_W=1 elaborates cleanly.
    always_comb begin
        shadow_shl    = shadow << 1;
        shadow_shl[0] = key_bit;
    end

    assign last = (cnt == LAST_C);
    assign full = (cnt == LOAD_LEN_C);

`ifdef RLL_KEY_PARITY_EN
    localparam logic [RLL_CNT_W-1:0] KEY_LEN_C = RLL_CNT_W'(KEY_W);

    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shadow  <= '0;
            par_bit <= 1'b0;
            cnt     <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            // The trailing bit after the key is parity and never enters the shadow.
            if (cnt < KEY_LEN_C) shadow <= shadow_shl;
            else                 par_bit <= key_bit;
            cnt <= cnt + 1'b1;
        end
    end

    assign parity_ok = ((^shadow) == par_bit);
`else
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            shadow <= shadow_shl;
            cnt    <= cnt + 1'b1;
        end
    end

    assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/rll_keyed_gate_bank.sv
// Sequential RLL key-gate bank: serially loaded shadow key, atomic commit, keyed data register.
// Optional key parity checking is enabled by RLL_KEY_PARITY_EN.
module rll_keyed_gate_bank
    import rll_pkg::*;
#(
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      KEY_W    = 32,
    parameter logic [KEY_W-1:0] GATE_POL = 32'hA5C3_0F96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_bit_i,
    input  logic              key_valid_i,
    output logic              key_ready_o,
    input  logic              key_commit_i,
    input  logic              key_clear_i,
    output logic              key_loaded_o,
    output logic              key_err_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o
);

`ifdef RLL_KEY_PARITY_EN
    localparam int unsigned LOAD_LEN = KEY_W + 1;
`else
    localparam int unsigned LOAD_LEN = KEY_W;
`endif

    rll_key_state_e   state;
    logic [KEY_W-1:0] active_key;
    logic [KEY_W-1:0] shadow;
    logic             last;
    logic             full;
    logic             parity_ok;
    logic             shift_en;
    logic             commit_ok;
    logic             err_q;

    logic [RLL_MAX_W-1:0] data_ext;
    logic [RLL_MAX_W-1:0] key_ext;
    logic [RLL_MAX_W-1:0] pol_ext;

    assign shift_en  = key_valid_i && key_ready_o;
    assign commit_ok = key_commit_i && (state == FULL) && full;
    assign key_err_o = err_q;

    rll_key_shifter #(
        .KEY_W    (KEY_W),
        .LOAD_LEN (LOAD_LEN)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clear     (key_clear_i),
        .cnt_clr   (commit_ok),
        .shift_en  (shift_en),
        .key_bit   (key_bit_i),
        .shadow    (shadow),
        .last      (last),
        .full      (full),
        .parity_ok (parity_ok)
    );

    // Ready is registered, so it is driven from the state being entered on each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            active_key   <= ~GATE_POL;
            key_loaded_o <= 1'b0;
            err_q        <= 1'b0;
            key_ready_o  <= 1'b0;
        end else if (key_clear_i) begin
            state        <= EMPTY;
            active_key   <= ~GATE_POL;
            key_loaded_o <= 1'b0;
            err_q        <= 1'b0;
            key_ready_o  <= 1'b1;
        end else if (commit_ok) begin
            key_ready_o <= 1'b1;
            if (parity_ok) begin
                state        <= ACTIVE;
                active_key   <= shadow;
                key_loaded_o <= 1'b1;
            end else begin
                state <= EMPTY;
                err_q <= 1'b1;
            end
        end else if (shift_en) begin
            state       <= last ? FULL : LOADING;
            key_ready_o <= !last;
        end else begin
            key_ready_o <= (state != FULL);
        end
    end

    always_comb begin
        data_ext = '0;
        key_ext  = '0;
        pol_ext  = '0;
        data_ext[DATA_W-1:0] = data_i;
        key_ext[KEY_W-1:0]   = active_key;
        pol_ext[KEY_W-1:0]   = GATE_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else begin
            data_o       <= DATA_W'(apply_key(data_ext, key_ext, pol_ext));
            data_valid_o <= data_valid_i;
        end
    end

endmodule

// File: tb/tb_rll_keyed_gate_bank.sv
// Directed self-checking bench for rll_keyed_gate_bank (default 32-bit and an 8-key/18-bit instance).
module tb_rll_keyed_gate_bank;
    import rll_pkg::*;

`ifdef RLL_KEY_PARITY_EN
    localparam int LOAD_LEN = 33;
`else
    localparam int LOAD_LEN = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_bit = 1'b0, key_valid = 1'b0, key_commit = 1'b0, key_clear = 1'b0;
    logic        key_ready, key_loaded, key_err;
    logic [31:0] data_i = '0;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_o;
    logic        data_valid_o;

    logic        kb8 = 1'b0, kv8 = 1'b0, kc8 = 1'b0, kcl8 = 1'b0;
    logic        kr8, kl8, ke8;
    logic [17:0] d8_i = 18'h3A5C3;
    logic        dv8_i = 1'b0;
    logic [17:0] d8_o;
    logic        dv8_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    rll_keyed_gate_bank dut (
        .clk          (clk),
        .rst          (rst),
        .key_bit_i    (key_bit),
        .key_valid_i  (key_valid),
        .key_ready_o  (key_ready),
        .key_commit_i (key_commit),
        .key_clear_i  (key_clear),
        .key_loaded_o (key_loaded),
        .key_err_o    (key_err),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o)
    );

    rll_keyed_gate_bank #(
        .DATA_W   (18),
        .KEY_W    (8),
        .GATE_POL (8'h96)
    ) dut8 (
        .clk          (clk),
        .rst          (rst),
        .key_bit_i    (kb8),
        .key_valid_i  (kv8),
        .key_ready_o  (kr8),
        .key_commit_i (kc8),
        .key_clear_i  (kcl8),
        .key_loaded_o (kl8),
        .key_err_o    (ke8),
        .data_i       (d8_i),
        .data_valid_i (dv8_i),
        .data_o       (d8_o),
        .data_valid_o (dv8_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MSB first; optionally follows with the even-parity bit (inverted when bad_par).
    task automatic shift_word(input bit which, input logic [31:0] k, input int n,
                              input bit add_par, input bit bad_par);
        logic p;
        p = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            p = p ^ k[i];
            if (which) begin kb8 = k[i]; kv8 = 1'b1; end
            else       begin key_bit = k[i]; key_valid = 1'b1; end
            tick();
        end
`ifdef RLL_KEY_PARITY_EN
        if (add_par) begin
            if (which) kb8 = p ^ bad_par;
            else       key_bit = p ^ bad_par;
            tick();
        end
`else
        if (add_par && bad_par) $display("note: parity bit requested in non-parity build");
`endif
        kv8 = 1'b0;
        key_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        check("rst_data", 64'(data_o), 64'h0);
        check("rst_ready", 64'(key_ready), 64'h0);
        rst = 1'b0;
        tick();
        // 1: locked output after reset
        check("locked_data", 64'(data_o), 64'hFFFF_FFFF);
        check("locked_loaded", 64'(key_loaded), 64'h0);
        check("locked_ready", 64'(key_ready), 64'h1);
        check("locked_err", 64'(key_err), 64'h0);
        check("locked_state", 64'(dut.state), 64'(EMPTY));
        check("w8_locked", 64'(d8_o), 64'h3A53C);

        // 2: correct key
        shift_word(1'b0, 32'hA5C3_0F96, 32, 1'b1, 1'b0);
        check("full_state", 64'(dut.state), 64'(FULL));
        check("full_ready", 64'(key_ready), 64'h0);
        check("full_cnt", 64'(dut.u_shifter.cnt), 64'(LOAD_LEN));
        data_i = 32'h1234_5678;
        data_valid_i = 1'b1;
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        data_valid_i = 1'b0;
        check("commit_edge_data", 64'(data_o), 64'hEDCB_A987);
        check("commit_edge_dv", 64'(data_valid_o), 64'h1);
        check("commit_loaded", 64'(key_loaded), 64'h1);
        check("commit_state", 64'(dut.state), 64'(ACTIVE));
        tick();
        check("unlocked_data", 64'(data_o), 64'h1234_5678);
        check("unlocked_dv", 64'(data_valid_o), 64'h0);

        // 3/4: reload keeps old key; commit wins over a simultaneous bit
        shift_word(1'b0, 32'hA5C3_0F97, 32, 1'b1, 1'b0);
        check("reload_hold", 64'(data_o), 64'h1234_5678);
        check("reload_state", 64'(dut.state), 64'(FULL));
        key_bit = 1'b1;
        key_valid = 1'b1;
        key_commit = 1'b1;
        tick();
        key_valid = 1'b0;
        key_commit = 1'b0;
        data_i = '0;
        check("race_cnt", 64'(dut.u_shifter.cnt), 64'h0);
        check("race_state", 64'(dut.state), 64'(ACTIVE));
        check("race_ready", 64'(key_ready), 64'h1);
        tick();
        check("wrong_key_data", 64'(data_o), 64'h0000_0001);

        // Commit during a partial load is ignored
        shift_word(1'b0, 32'h0000_03FF, 10, 1'b0, 1'b0);
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        check("partial_state", 64'(dut.state), 64'(LOADING));
        check("partial_cnt", 64'(dut.u_shifter.cnt), 64'd10);
        tick();
        check("partial_data", 64'(data_o), 64'h0000_0001);

        // 5: reset mid-load
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 64'(dut.state), 64'(EMPTY));
        check("midrst_cnt", 64'(dut.u_shifter.cnt), 64'h0);
        check("midrst_loaded", 64'(key_loaded), 64'h0);
        tick();
        check("midrst_relock", 64'(data_o), 64'hFFFF_FFFF);
        check("midrst_ready", 64'(key_ready), 64'h1);
        shift_word(1'b0, 32'hA5C3_0F96, 32, 1'b1, 1'b0);
        data_i = 32'hCAFE_F00D;
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        tick();
        check("reload_data", 64'(data_o), 64'hCAFE_F00D);

        // Clear relocks
        data_i = '0;
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("clear_loaded", 64'(key_loaded), 64'h0);
        check("clear_state", 64'(dut.state), 64'(EMPTY));
        tick();
        check("clear_data", 64'(data_o), 64'hFFFF_FFFF);

`ifdef RLL_KEY_PARITY_EN
        // 6: parity mismatch keeps the committed key
        shift_word(1'b0, 32'hA5C3_0F96, 32, 1'b1, 1'b0);
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        tick();
        check("par_good_data", 64'(data_o), 64'h0);
        check("par_good_err", 64'(key_err), 64'h0);
        shift_word(1'b0, 32'hA5C3_0F97, 32, 1'b1, 1'b1);
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        check("par_bad_err", 64'(key_err), 64'h1);
        check("par_bad_state", 64'(dut.state), 64'(EMPTY));
        tick();
        check("par_bad_data", 64'(data_o), 64'h0);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("par_clear_err", 64'(key_err), 64'h0);
`else
        check("err_tied", 64'(key_err), 64'h0);
`endif

        // 7: narrow key, upper data bits pass through
        shift_word(1'b1, 32'h0000_0096, 8, 1'b1, 1'b0);
        check("w8_full_upper", 64'(d8_o[17:8]), 64'h3A5);
        kc8 = 1'b1;
        tick();
        kc8 = 1'b0;
        tick();
        check("w8_unlocked", 64'(d8_o), 64'h3A5C3);
        d8_i = 18'h155AA;
        tick();
        check("w8_unlocked2", 64'(d8_o), 64'h155AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
